// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: arbiter state/owner encodings and the
// default bus widths used by the caches, write buffer and memory model.
package mem_pkg;

  localparam int DEF_AW      = 30;
  localparam int DEF_DW      = 32;
  localparam int DEF_BEW     = DEF_DW / 8;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_WB,
    OWN_D,
    OWN_I
  } owner_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog for the memory arbiter. Counts cycles while enabled and
// flags expiry on the cycle whose closing edge is the TIMEOUT-th busy edge.
module mem_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Expiry is seen one count early so the abort lands on edge TIMEOUT itself.
  assign expired = enable && (count_q == LAST);

  // Next count: clear wins, otherwise advance while enabled, saturating at LAST.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: serialises write-buffer, dcache and icache requests onto the
// single main-memory port, returns registered read data with a one-cycle done
// pulse, and aborts transactions that exceed the watchdog limit.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int BEW     = DEF_BEW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wben,
  input  logic           dben,
  input  logic           iben,
  input  logic [AW-1:0]  wbadr,
  input  logic [AW-1:0]  dadr,
  input  logic [AW-1:0]  iadr,
  input  logic [DW-1:0]  wbdata,
  input  logic [BEW-1:0] wbbyteen,
  output logic           wbdone,
  output logic           ddone,
  output logic           idone,
  output logic [DW-1:0]  rdata,
  output logic           err,
  output logic [AW-1:0]  memadr,
  output logic [DW-1:0]  memwdata,
  output logic [BEW-1:0] membyteen,
  output logic           memrwb,
  output logic           memen,
  input  logic [DW-1:0]  memrdata,
  input  logic           memdone
);

  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  logic           prefer_i_q, prefer_i_d;
  logic [AW-1:0]  memadr_q, memadr_d;
  logic [DW-1:0]  memwdata_q, memwdata_d;
  logic [BEW-1:0] membyteen_q, membyteen_d;
  logic           memrwb_q, memrwb_d;
  logic           memen_q, memen_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           wdog_clear, wdog_enable, wdog_expired;

  mem_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdog_clear),
    .enable (wdog_enable),
    .expired(wdog_expired)
  );

  assign memadr    = memadr_q;
  assign memwdata  = memwdata_q;
  assign membyteen = membyteen_q;
  assign memrwb    = memrwb_q;
  assign memen     = memen_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign wbdone    = (state_q == RESP) && (owner_q == OWN_WB);
  assign ddone     = (state_q == RESP) && (owner_q == OWN_D);
  assign idone     = (state_q == RESP) && (owner_q == OWN_I);

  // Next-state logic: grant selection in IDLE, completion/abort in BUSY,
  // round-robin bookkeeping in RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prefer_i_d  = prefer_i_q;
    memadr_d    = memadr_q;
    memwdata_d  = memwdata_q;
    membyteen_d = membyteen_q;
    memrwb_d    = memrwb_q;
    memen_d     = memen_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    wdog_clear  = 1'b0;
    wdog_enable = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_clear = 1'b1;
        err_d      = 1'b0;
        if (wben) begin
          owner_d     = OWN_WB;
          memadr_d    = wbadr;
          memwdata_d  = wbdata;
          membyteen_d = wbbyteen;
          memrwb_d    = 1'b0;
          memen_d     = 1'b1;
          state_d     = BUSY;
        end else if (dben && (!iben || !prefer_i_q)) begin
          owner_d     = OWN_D;
          memadr_d    = dadr;
          memwdata_d  = '0;
          membyteen_d = '1;
          memrwb_d    = 1'b1;
          memen_d     = 1'b1;
          state_d     = BUSY;
        end else if (iben) begin
          owner_d     = OWN_I;
          memadr_d    = iadr;
          memwdata_d  = '0;
          membyteen_d = '1;
          memrwb_d    = 1'b1;
          memen_d     = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        wdog_enable = 1'b1;
        if (memdone) begin
          memen_d = 1'b0;
          err_d   = 1'b0;
          if (memrwb_q) begin
            rdata_d = memrdata;
          end
          state_d = RESP;
        end else if (wdog_expired) begin
          memen_d = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
        if (owner_q == OWN_D) begin
          prefer_i_d = 1'b1;
        end else if (owner_q == OWN_I) begin
          prefer_i_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        memen_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      prefer_i_q  <= 1'b0;
      memadr_q    <= '0;
      memwdata_q  <= '0;
      membyteen_q <= '0;
      memrwb_q    <= 1'b0;
      memen_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prefer_i_q  <= prefer_i_d;
      memadr_q    <= memadr_d;
      memwdata_q  <= memwdata_d;
      membyteen_q <= membyteen_d;
      memrwb_q    <= memrwb_d;
      memen_q     <= memen_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// request/latency traffic, compared against a transaction-level model of the
// arbitration and completion rules.
module tb_mem_arbiter;

  localparam int AW      = 30;
  localparam int DW      = 32;
  localparam int BEW     = 4;
  localparam int TIMEOUT = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           wben = 1'b0, dben = 1'b0, iben = 1'b0;
  logic [AW-1:0]  wbadr = '0, dadr = '0, iadr = '0;
  logic [DW-1:0]  wbdata = '0;
  logic [BEW-1:0] wbbyteen = '0;
  logic           wbdone, ddone, idone;
  logic [DW-1:0]  rdata;
  logic           err;
  logic [AW-1:0]  memadr;
  logic [DW-1:0]  memwdata;
  logic [BEW-1:0] membyteen;
  logic           memrwb, memen;
  logic [DW-1:0]  memrdata = '0;
  logic           memdone = 1'b0;

  int          checks = 0;
  int          errors = 0;
  bit          last_read_was_d = 1'b0;
  logic [31:0] order_log = '0;

  mem_arbiter #(
    .AW(AW), .DW(DW), .BEW(BEW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .wben(wben), .dben(dben), .iben(iben),
    .wbadr(wbadr), .dadr(dadr), .iadr(iadr),
    .wbdata(wbdata), .wbbyteen(wbbyteen),
    .wbdone(wbdone), .ddone(ddone), .idone(idone),
    .rdata(rdata), .err(err),
    .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen),
    .memrwb(memrwb), .memen(memen),
    .memrdata(memrdata), .memdone(memdone)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Raise/lower request levels; a port that newly raises gets fresh fields.
  task automatic applyStimulus(input logic w, input logic d, input logic i);
    if (w && !wben) begin
      wbadr    = AW'($urandom());
      wbdata   = $urandom();
      wbbyteen = BEW'($urandom_range(1, 15));
    end
    if (d && !dben) dadr = AW'($urandom());
    if (i && !iben) iadr = AW'($urandom());
    wben = w;
    dben = d;
    iben = i;
  endtask

  // Arbitration rule: 1=WB, 2=D, 3=I, 0=nobody.
  function automatic int modelWinner();
    if (wben) return 1;
    if (dben && iben) return last_read_was_d ? 3 : 2;
    if (dben) return 2;
    if (iben) return 3;
    return 0;
  endfunction

  // One full transaction from an IDLE sample edge to back in IDLE.
  // lat > TIMEOUT means memory never answers.
  task automatic doTransaction(input int lat, input logic [DW-1:0] rd);
    int             exp_own, obs_own, n;
    bit             timed_out, stable;
    logic [AW-1:0]  e_adr;
    logic           e_rwb;
    logic [BEW-1:0] e_be;
    logic [DW-1:0]  e_wd;
    exp_own = modelWinner();
    if (exp_own == 0) begin
      $display("[TB] doTransaction called with no request");
      return;
    end
    e_wd = '0;
    case (exp_own)
      1:       begin e_adr = wbadr; e_rwb = 1'b0; e_be = wbbyteen; e_wd = wbdata; end
      2:       begin e_adr = dadr;  e_rwb = 1'b1; e_be = '1; end
      default: begin e_adr = iadr;  e_rwb = 1'b1; e_be = '1; end
    endcase
    @(negedge clk);
    checkOutput("grant_memen", memen, 1'b1);
    checkOutput("grant_adr", memadr, e_adr);
    checkOutput("grant_rwb", memrwb, e_rwb);
    checkOutput("grant_be", membyteen, e_be);
    if (exp_own == 1) checkOutput("grant_wdata", memwdata, e_wd);
    timed_out = (lat > TIMEOUT);
    n = timed_out ? TIMEOUT : lat;
    stable = 1'b1;
    for (int k = 1; k <= n; k++) begin
      memdone  = (!timed_out && k == n);
      memrdata = memdone ? rd : $urandom();
      @(negedge clk);
      memdone = 1'b0;
      if (k < n) begin
        if (memen !== 1'b1 || memadr !== e_adr || memrwb !== e_rwb ||
            membyteen !== e_be || (wbdone | ddone | idone) !== 1'b0 ||
            (exp_own == 1 && memwdata !== e_wd))
          stable = 1'b0;
      end
    end
    checkOutput("busy_stable", stable, 1'b1);
    checkOutput("resp_memen", memen, 1'b0);
    case ({wbdone, ddone, idone})
      3'b100:  obs_own = 1;
      3'b010:  obs_own = 2;
      3'b001:  obs_own = 3;
      default: obs_own = 0;
    endcase
    checkOutput("resp_owner", obs_own, exp_own);
    checkOutput("resp_err", err, timed_out);
    if (exp_own != 1) checkOutput("resp_rdata", rdata, timed_out ? '0 : rd);
    order_log = {order_log[27:0], obs_own[3:0]};
    if (exp_own == 2) last_read_was_d = 1'b1;
    if (exp_own == 3) last_read_was_d = 1'b0;
    case (exp_own)
      1:       wben = 1'b0;
      2:       dben = 1'b0;
      default: iben = 1'b0;
    endcase
    @(negedge clk);
    checkOutput("done_pulse_end", {wbdone, ddone, idone}, 3'b000);
    checkOutput("idle_memen", memen, 1'b0);
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    #1;
    checkOutput("rst_memen", memen, 1'b0);
    checkOutput("rst_done", {wbdone, ddone, idone}, 3'b000);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_rdata", rdata, '0);
    checkOutput("rst_memrwb", memrwb, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] all three ports request together");
    applyStimulus(1'b1, 1'b1, 1'b1);
    order_log = '0;
    for (int t = 0; t < 3; t++) doTransaction(1, $urandom());
    checkOutput("order_wb_d_i", order_log[11:0], 12'h123);

    $display("[TB] dcache and icache contend");
    applyStimulus(1'b0, 1'b1, 1'b1);
    order_log = '0;
    for (int t = 0; t < 5; t++) begin
      doTransaction(1 + t % 3, $urandom());
      if (t < 2) applyStimulus(1'b0, 1'b1, 1'b1);
      else if (t == 2) applyStimulus(1'b0, 1'b1, iben);
    end
    checkOutput("order_rr", order_log[19:0], 20'h23232);

    $display("[TB] single dcache read");
    applyStimulus(1'b0, 1'b1, 1'b0);
    dadr = 30'h4AD;
    doTransaction(2, 32'h21212121);
    checkOutput("d_read_rdata_hold", rdata, 32'h21212121);

    $display("[TB] reset in the middle of a transaction");
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_memen", memen, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_memen", memen, 1'b0);
    checkOutput("mid_rst_done", {wbdone, ddone, idone}, 3'b000);
    checkOutput("mid_rst_err", err, 1'b0);
    checkOutput("mid_rst_rdata", rdata, '0);
    checkOutput("mid_rst_memadr", memadr, '0);
    checkOutput("mid_rst_membyteen", membyteen, '0);
    checkOutput("mid_rst_memrwb", memrwb, 1'b0);
    dben = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_read_was_d = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    doTransaction(2, $urandom());

    $display("[TB] icache read with no memory answer");
    applyStimulus(1'b0, 1'b0, 1'b1);
    doTransaction(TIMEOUT + 1, $urandom());

    $display("[TB] stray memdone while idle");
    applyStimulus(1'b0, 1'b0, 1'b0);
    memdone  = 1'b1;
    memrdata = $urandom();
    @(negedge clk);
    memdone = 1'b0;
    checkOutput("stray_done", {wbdone, ddone, idone}, 3'b000);
    checkOutput("stray_memen", memen, 1'b0);
    @(negedge clk);
    checkOutput("stray_done2", {wbdone, ddone, idone}, 3'b000);
    checkOutput("stray_memen2", memen, 1'b0);

    $display("[TB] random traffic");
    for (int t = 0; t < 30; t++) begin
      logic w, d, i;
      w = wben | ($urandom_range(0, 3) == 0);
      d = dben | 1'($urandom_range(0, 1));
      i = iben | 1'($urandom_range(0, 1));
      if (!(w | d | i)) d = 1'b1;
      applyStimulus(w, d, i);
      doTransaction(int'($urandom_range(1, TIMEOUT + 2)), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
